cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
- Multicycle control FSM sitting directly upstream of the 16-bit datapath (register file, ALU, PC, immediate/address registers).
- Fetches a 16-bit instruction over a ready handshake, decodes it, and sequences every datapath enable, mux select, ALU opcode, register address and immediate value.
- Includes the PC-increment step.
- Replaces the tied-off control constants and board switches that currently drive the datapath.

Parameters:
- REG_WIDTH, 16, datapath/instruction width
- REG_ADDR_BITS, 3, register address width; the low REG_ADDR_BITS of each 4-bit instruction register field are used
- ADD_OPEXT, 4'h5, aluOpCode for R-type ADD, used for the PC increment
- CMP_OPEXT, 4'hB, opcode/opext for CMP; CMP never writes the register file

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- instr  input  REG_WIDTH  instruction word from instruction memory
- instrReady  input  1  instr valid this cycle
- memRead  output  1  instruction fetch request at current pcOut
- srcAddressRegEnable  output  1  load source address register
- dstAddressRegEnable  output  1  load destination address register
- immediateRegEnable  output  1  load immediate register
- regWriteEnable  output  1  register file write
- aluOutputRegEnable  output  1  load ALU output register
- pcEnable  output  1  load PC from ALU output
- aluInputAMuxSelect  output  1  0 = regReadData1, 1 = pcOut
- aluInputBMuxSelect  output  1  0 = regReadData2, 1 = immediateRegOut
- aluOpCode  output  4  ALU control opcode
- instrType  output  1  0 = R-type, 1 = immediate-type
- regAddressA  output  REG_ADDR_BITS  source register (Rsrc)
- regAddressB  output  REG_ADDR_BITS  destination register (Rdest)
- immediate  output  REG_WIDTH  value for the immediate register
- halted  output  1  FSM halted (see Optional Feature)
- retiredCount  output  16  instructions completed, wraps 16'hFFFF -> 0

Behaviour:
- Registered state: state, IR[15:0], retiredCount. All outputs are combinational from state and IR (Moore).
- Reset (reset=0, asynchronous): state=S_RESET, IR=0, retiredCount=0.
  - In S_RESET every output is 0, including memRead, immediate and halted.
  - Reset mid-instruction abandons it; no write enable may stay asserted after reset asserts.
- Instruction decode (IR):
  - op = IR[15:12], Rdest = IR[11:8], opext = IR[7:4], Rsrc = IR[3:0].
  - op == 0: R-type. instrType=0, aluOpCode=opext.
  - op != 0: I-type. instrType=1, aluOpCode=op, immediate = sign-extended IR[7:0].
- S_RESET -> S_FETCH unconditionally.
- S_FETCH:
  - memRead=1.
  - Waits while instrReady=0.
  - On the edge where instrReady=1, IR <= instr, go to S_DECODE.
  - instrReady in any other state is ignored.
- S_DECODE:
  - regAddressA=Rsrc[REG_ADDR_BITS-1:0], regAddressB=Rdest[REG_ADDR_BITS-1:0].
  - srcAddressRegEnable=1, dstAddressRegEnable=1.
  - immediateRegEnable=1 with the decoded immediate (0 for R-type).
  - Next state S_EXECUTE.
- S_EXECUTE:
  - aluInputAMuxSelect=0, aluInputBMuxSelect=instrType.
  - aluOpCode and instrType as decoded.
  - aluOutputRegEnable=1.
  - regWriteEnable=1 unless the decoded op is CMP (R-type opext==CMP_OPEXT or I-type op==CMP_OPEXT).
  - Register file captures aluOutput into Rdest at the end of this cycle.
  - Next state S_PCLOAD.
- S_PCLOAD: immediate=16'h0001, immediateRegEnable=1; next state S_PCINC.
- S_PCINC:
  - aluInputAMuxSelect=1, aluInputBMuxSelect=1, instrType=0, aluOpCode=ADD_OPEXT.
  - pcEnable=1.
  - retiredCount increments.
  - Next state S_FETCH.
- Throughput: 5 cycles per instruction plus fetch wait cycles (a minimum of 1 cycle in S_FETCH).
- regAddressA/B hold their S_DECODE values through S_EXECUTE; they are 0 in all other states.
- In every state, any output not listed for that state is 0.

Optional Feature:
- Macro CPU_CONTROLLER_HALT_EN.
- Defined:
  - In S_DECODE, IR==16'hFFFF goes to S_HALT instead of S_EXECUTE.
  - S_HALT: halted=1, all other outputs 0, retiredCount frozen; exit only by reset.
- Undefined: no S_HALT; 16'hFFFF executes as a normal I-type instruction (op=F, imm=16'hFFFF); halted tied 0.

Test Plan:
- Reset released, instrReady=0 for 3 cycles -> S_RESET outputs all 0; memRead=1 held 3 cycles; no enable asserts.
- instr=16'h0153 (R-type ADD, Rdest=1, Rsrc=3) -> DECODE: regAddressA=3, regAddressB=1; EXECUTE: aluOpCode=5, instrType=0, muxB=0, regWriteEnable=1; PCINC: pcEnable=1, muxA=1, muxB=1; retiredCount=1.
- instr=16'h52F0 (I-type op 5, Rdest=2, imm F0) -> immediate=16'hFFF0 in DECODE; instrType=1, muxB=1 in EXECUTE; then immediate=16'h0001 in PCLOAD.
- instr=16'h02B1 (CMP) and instr=16'hB27F -> regWriteEnable stays 0 for the whole instruction; aluOutputRegEnable=1 in EXECUTE.
- reset pulsed low during S_EXECUTE -> all outputs 0 immediately (asynchronous); retiredCount=0; S_FETCH after release.
- With CPU_CONTROLLER_HALT_EN, instr=16'hFFFF -> halted=1 from the cycle after DECODE, memRead stays 0 for 20 cycles; without the macro -> aluOpCode=F, instrType=1, normal retire.

Source files
------------

// File: rtl/cpu_controller.sv
// Multicycle control FSM for the 16-bit datapath: fetch, decode, execute, PC increment.
// Optional halt state on IR == 16'hFFFF is built when CPU_CONTROLLER_HALT_EN is defined.
module cpu_controller #(
    parameter int unsigned REG_WIDTH     = 16,
    parameter int unsigned REG_ADDR_BITS = 3,
    parameter logic [3:0]  ADD_OPEXT     = 4'h5,
    parameter logic [3:0]  CMP_OPEXT     = 4'hB
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REG_WIDTH-1:0]     instr,
    input  logic                     instrReady,
    output logic                     memRead,
    output logic                     srcAddressRegEnable,
    output logic                     dstAddressRegEnable,
    output logic                     immediateRegEnable,
    output logic                     regWriteEnable,
    output logic                     aluOutputRegEnable,
    output logic                     pcEnable,
    output logic                     aluInputAMuxSelect,
    output logic                     aluInputBMuxSelect,
    output logic [3:0]               aluOpCode,
    output logic                     instrType,
    output logic [REG_ADDR_BITS-1:0] regAddressA,
    output logic [REG_ADDR_BITS-1:0] regAddressB,
    output logic [REG_WIDTH-1:0]     immediate,
    output logic                     halted,
    output logic [15:0]              retiredCount
);

    typedef enum logic [2:0] {
        StReset,
        StFetch,
        StDecode,
        StExecute,
        StPcLoad,
        StPcInc,
        StHalt
    } state_e;

    state_e                 state_q, state_d;
    logic [REG_WIDTH-1:0]   ir_q, ir_d;
    logic [15:0]            retired_q, retired_d;

    logic [3:0]             op, opext;
    logic                   is_rtype, is_cmp, halt_instr;
    logic [3:0]             dec_aluop;
    logic [REG_WIDTH-1:0]   dec_imm;
    logic                   unused_ir;

    assign op        = ir_q[15:12];
    assign opext     = ir_q[7:4];
    assign is_rtype  = (op == 4'h0);
    assign dec_aluop = is_rtype ? opext : op;
    assign dec_imm   = is_rtype ? '0 : {{(REG_WIDTH-8){ir_q[7]}}, ir_q[7:0]};
    assign is_cmp    = is_rtype ? (opext == CMP_OPEXT) : (op == CMP_OPEXT);
    assign unused_ir = ^ir_q;

`ifdef CPU_CONTROLLER_HALT_EN
    assign halt_instr = (ir_q == '1);
`else
    assign halt_instr = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StReset;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    assign retiredCount = retired_q;

    always_comb begin
        state_d             = state_q;
        ir_d                = ir_q;
        retired_d           = retired_q;
        memRead             = 1'b0;
        srcAddressRegEnable = 1'b0;
        dstAddressRegEnable = 1'b0;
        immediateRegEnable  = 1'b0;
        regWriteEnable      = 1'b0;
        aluOutputRegEnable  = 1'b0;
        pcEnable            = 1'b0;
        aluInputAMuxSelect  = 1'b0;
        aluInputBMuxSelect  = 1'b0;
        aluOpCode           = 4'h0;
        instrType           = 1'b0;
        regAddressA         = '0;
        regAddressB         = '0;
        immediate           = '0;
        halted              = 1'b0;

        case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                memRead = 1'b1;
                if (instrReady) begin
                    ir_d    = instr;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                regAddressA         = ir_q[REG_ADDR_BITS-1:0];
                regAddressB         = ir_q[8 +: REG_ADDR_BITS];
                srcAddressRegEnable = 1'b1;
                dstAddressRegEnable = 1'b1;
                immediateRegEnable  = 1'b1;
                immediate           = dec_imm;
                state_d             = halt_instr ? StHalt : StExecute;
            end
            StExecute: begin
                regAddressA        = ir_q[REG_ADDR_BITS-1:0];
                regAddressB        = ir_q[8 +: REG_ADDR_BITS];
                aluInputBMuxSelect = ~is_rtype;
                aluOpCode          = dec_aluop;
                instrType          = ~is_rtype;
                aluOutputRegEnable = 1'b1;
                regWriteEnable     = ~is_cmp;
                state_d            = StPcLoad;
            end
            StPcLoad: begin
                immediate          = REG_WIDTH'(1);
                immediateRegEnable = 1'b1;
                state_d            = StPcInc;
            end
            StPcInc: begin
                // PC + 1 through the ALU using the immediate loaded in StPcLoad
                aluInputAMuxSelect = 1'b1;
                aluInputBMuxSelect = 1'b1;
                aluOpCode          = ADD_OPEXT;
                pcEnable           = 1'b1;
                retired_d          = retired_q + 16'd1;
                state_d            = StFetch;
            end
`ifdef CPU_CONTROLLER_HALT_EN
            StHalt: halted = 1'b1;
`endif
            default: state_d = StReset;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller; all output ports are packed into one vector.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instrReady;
    logic        memRead, srcAddressRegEnable, dstAddressRegEnable, immediateRegEnable;
    logic        regWriteEnable, aluOutputRegEnable, pcEnable;
    logic        aluInputAMuxSelect, aluInputBMuxSelect;
    logic [3:0]  aluOpCode;
    logic        instrType;
    logic [2:0]  regAddressA, regAddressB;
    logic [15:0] immediate;
    logic        halted;
    logic [15:0] retiredCount;
    logic [36:0] outs;

    int vectors = 0;
    int miscompares = 0;

    cpu_controller dut (
        .clk                 (clk),
        .reset               (reset),
        .instr               (instr),
        .instrReady          (instrReady),
        .memRead             (memRead),
        .srcAddressRegEnable (srcAddressRegEnable),
        .dstAddressRegEnable (dstAddressRegEnable),
        .immediateRegEnable  (immediateRegEnable),
        .regWriteEnable      (regWriteEnable),
        .aluOutputRegEnable  (aluOutputRegEnable),
        .pcEnable            (pcEnable),
        .aluInputAMuxSelect  (aluInputAMuxSelect),
        .aluInputBMuxSelect  (aluInputBMuxSelect),
        .aluOpCode           (aluOpCode),
        .instrType           (instrType),
        .regAddressA         (regAddressA),
        .regAddressB         (regAddressB),
        .immediate           (immediate),
        .halted              (halted),
        .retiredCount        (retiredCount)
    );

    always #5 clk = ~clk;

    assign outs = {memRead, srcAddressRegEnable, dstAddressRegEnable, immediateRegEnable,
                   regWriteEnable, aluOutputRegEnable, pcEnable, aluInputAMuxSelect,
                   aluInputBMuxSelect, aluOpCode, instrType, regAddressA, regAddressB,
                   immediate, halted};

    function automatic logic [36:0] mk(input logic mr, src, dst, ie, we, aoe, pce, ma, mb,
                                       input logic [3:0] op, input logic it,
                                       input logic [2:0] ra, rb, input logic [15:0] imm,
                                       input logic h);
        return {mr, src, dst, ie, we, aoe, pce, ma, mb, op, it, ra, rb, imm, h};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in StFetch; returns sampling in StDecode.
    task automatic issue(input logic [15:0] ins);
        instr      = ins;
        instrReady = 1'b1;
        tick();
        instrReady = 1'b0;
        instr      = 16'h0000;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        instr      = 16'h0000;
        instrReady = 1'b0;
        #3;
        vectors++;
        if (outs !== 37'h0 || retiredCount !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_async: got %h/%h, want 0/0", outs, retiredCount);
        end
        tick();
        tick();
        reset = 1'b1;
        vectors++;
        if (outs !== 37'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h, want 0", outs);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (outs !== mk(1,0,0,0,0,0,0,0,0,4'h0,0,3'd0,3'd0,16'h0,0)) begin
                miscompares++;
                $display("FAIL fetch_wait[%0d]: got %h, want memRead only", i, outs);
            end
        end
    endtask

    task automatic test_add();
        logic [36:0] exp [5];
        exp[0] = mk(0,1,1,1,0,0,0,0,0,4'h0,0,3'd3,3'd1,16'h0000,0);
        exp[1] = mk(0,0,0,0,1,1,0,0,0,4'h5,0,3'd3,3'd1,16'h0000,0);
        exp[2] = mk(0,0,0,1,0,0,0,0,0,4'h0,0,3'd0,3'd0,16'h0001,0);
        exp[3] = mk(0,0,0,0,0,0,1,1,1,4'h5,0,3'd0,3'd0,16'h0000,0);
        exp[4] = mk(1,0,0,0,0,0,0,0,0,4'h0,0,3'd0,3'd0,16'h0000,0);
        issue(16'h0153);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            vectors++;
            if (outs !== exp[i]) begin
                miscompares++;
                $display("FAIL add[%0d]: got %h, want %h", i, outs, exp[i]);
            end
        end
        vectors++;
        if (retiredCount !== 16'd1) begin
            miscompares++;
            $display("FAIL add_retired: got %0d, want 1", retiredCount);
        end
    endtask

    task automatic test_itype();
        logic [36:0] exp [5];
        exp[0] = mk(0,1,1,1,0,0,0,0,0,4'h0,0,3'd0,3'd2,16'hFFF0,0);
        exp[1] = mk(0,0,0,0,1,1,0,0,1,4'h5,1,3'd0,3'd2,16'h0000,0);
        exp[2] = mk(0,0,0,1,0,0,0,0,0,4'h0,0,3'd0,3'd0,16'h0001,0);
        exp[3] = mk(0,0,0,0,0,0,1,1,1,4'h5,0,3'd0,3'd0,16'h0000,0);
        exp[4] = mk(1,0,0,0,0,0,0,0,0,4'h0,0,3'd0,3'd0,16'h0000,0);
        issue(16'h52F0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            vectors++;
            if (outs !== exp[i]) begin
                miscompares++;
                $display("FAIL itype[%0d]: got %h, want %h", i, outs, exp[i]);
            end
        end
        vectors++;
        if (retiredCount !== 16'd2) begin
            miscompares++;
            $display("FAIL itype_retired: got %0d, want 2", retiredCount);
        end
    endtask

    task automatic test_reset_mid();
        issue(16'h0153);
        tick();
        vectors++;
        if (regWriteEnable !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_exec_we: got %b, want 1", regWriteEnable);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (outs !== 37'h0 || retiredCount !== 16'h0) begin
            miscompares++;
            $display("FAIL mid_reset_async: got %h/%h, want 0/0", outs, retiredCount);
        end
        tick();
        reset = 1'b1;
        vectors++;
        if (outs !== 37'h0) begin
            miscompares++;
            $display("FAIL mid_reset_hold: got %h, want 0", outs);
        end
        tick();
        vectors++;
        if (outs !== mk(1,0,0,0,0,0,0,0,0,4'h0,0,3'd0,3'd0,16'h0,0) || retiredCount !== 16'h0) begin
            miscompares++;
            $display("FAIL mid_reset_fetch: got %h/%h, want memRead only/0", outs, retiredCount);
        end
    endtask

    task automatic test_cmp();
        logic [36:0] exp [2][5];
        logic [15:0] ins [2];
        ins[0] = 16'h02B1;
        ins[1] = 16'hB27F;
        exp[0][0] = mk(0,1,1,1,0,0,0,0,0,4'h0,0,3'd1,3'd2,16'h0000,0);
        exp[0][1] = mk(0,0,0,0,0,1,0,0,0,4'hB,0,3'd1,3'd2,16'h0000,0);
        exp[1][0] = mk(0,1,1,1,0,0,0,0,0,4'h0,0,3'd7,3'd2,16'h007F,0);
        exp[1][1] = mk(0,0,0,0,0,1,0,0,1,4'hB,1,3'd7,3'd2,16'h0000,0);
        for (int k = 0; k < 2; k++) begin
            exp[k][2] = mk(0,0,0,1,0,0,0,0,0,4'h0,0,3'd0,3'd0,16'h0001,0);
            exp[k][3] = mk(0,0,0,0,0,0,1,1,1,4'h5,0,3'd0,3'd0,16'h0000,0);
            exp[k][4] = mk(1,0,0,0,0,0,0,0,0,4'h0,0,3'd0,3'd0,16'h0000,0);
            issue(ins[k]);
            for (int i = 0; i < 5; i++) begin
                if (i > 0) tick();
                vectors++;
                if (outs !== exp[k][i]) begin
                    miscompares++;
                    $display("FAIL cmp%0d[%0d]: got %h, want %h", k, i, outs, exp[k][i]);
                end
            end
            vectors++;
            if (retiredCount !== 16'(k + 1)) begin
                miscompares++;
                $display("FAIL cmp%0d_retired: got %0d, want %0d", k, retiredCount, k + 1);
            end
        end
    endtask

    task automatic test_ffff();
        logic [36:0] dec;
        dec = mk(0,1,1,1,0,0,0,0,0,4'h0,0,3'd7,3'd7,16'hFFFF,0);
        issue(16'hFFFF);
        vectors++;
        if (outs !== dec) begin
            miscompares++;
            $display("FAIL ffff_decode: got %h, want %h", outs, dec);
        end
`ifdef CPU_CONTROLLER_HALT_EN
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (outs !== mk(0,0,0,0,0,0,0,0,0,4'h0,0,3'd0,3'd0,16'h0,1) ||
                retiredCount !== 16'd2) begin
                miscompares++;
                $display("FAIL halt[%0d]: got %h/%0d, want halted only/2", i, outs, retiredCount);
            end
        end
`else
        begin
            logic [36:0] exp [4];
            exp[0] = mk(0,0,0,0,1,1,0,0,1,4'hF,1,3'd7,3'd7,16'h0000,0);
            exp[1] = mk(0,0,0,1,0,0,0,0,0,4'h0,0,3'd0,3'd0,16'h0001,0);
            exp[2] = mk(0,0,0,0,0,0,1,1,1,4'h5,0,3'd0,3'd0,16'h0000,0);
            exp[3] = mk(1,0,0,0,0,0,0,0,0,4'h0,0,3'd0,3'd0,16'h0000,0);
            for (int i = 0; i < 4; i++) begin
                tick();
                vectors++;
                if (outs !== exp[i]) begin
                    miscompares++;
                    $display("FAIL ffff[%0d]: got %h, want %h", i, outs, exp[i]);
                end
            end
            vectors++;
            if (retiredCount !== 16'd3) begin
                miscompares++;
                $display("FAIL ffff_retired: got %0d, want 3", retiredCount);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_itype();
        test_reset_mid();
        test_cmp();
        test_ffff();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
